avalon_packet_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one Avalon-ST output stream among NUM_PORTS Avalon-ST requesters.
- Sits downstream of the per-source enforcers, so its inputs are protocol-clean, and drives a shared sink such as a framer or FIFO.
- Once a packet is granted on sop, the grant is held until the matching eop beat is accepted, so packets are never interleaved.
- Zero-latency pass-through; no data storage.

---
 rtl/avalon_packet_arbiter.sv | 138 +++++++++++++
 tb/tb_avalon_packet_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_packet_arbiter.sv
`default_nettype none
// ============================================================================
// avalon_packet_arbiter: packet-level round-robin Avalon-ST arbiter, zero latency
// Revision: 1.0
// ============================================================================
module avalon_packet_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int EMPTY_WIDTH = 1,
  parameter int NUM_PORTS   = 4,
  parameter int IDX_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_valid,
  output logic [NUM_PORTS-1:0]             in_ready,
  input  logic [NUM_PORTS-1:0]             in_sop,
  input  logic [NUM_PORTS-1:0]             in_eop,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [EMPTY_WIDTH-1:0]           out_empty,
  output logic [IDX_WIDTH-1:0]             grant_idx,
  output logic                             busy,
  output logic                             stray_drop
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_WIDTH-1:0] r_grant_idx, w_grant_nxt;
  logic                 r_stray_drop;
  logic [IDX_WIDTH-1:0] w_win_idx, w_sel;
  logic                 w_win_found, w_fwd;
  logic [NUM_PORTS-1:0] w_cand, w_drain;

  assign w_cand = in_valid & in_sop;

  // Round-robin search starting just after the last port served.
  always_comb begin : g_win_search
    int                   v_p;
    logic [IDX_WIDTH-1:0] v_idx;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      v_p = int'(r_rr_ptr) + k;
      if (v_p >= NUM_PORTS) v_p = v_p - NUM_PORTS;
      v_idx = IDX_WIDTH'(v_p);
      if (!w_win_found && w_cand[v_idx]) begin
        w_win_found = 1'b1;
        w_win_idx   = v_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant_idx;
    w_drain      = '0;
    w_sel        = r_grant_idx;
    w_fwd        = 1'b0;
    in_ready     = '0;
    out_valid    = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_data     = '0;
    out_empty    = '0;

    case (r_state)
      ST_IDLE: begin
        w_drain  = in_valid & ~in_sop;
        in_ready = w_drain;
        if (w_win_found) begin
          w_sel               = w_win_idx;
          w_fwd               = 1'b1;
          out_valid           = 1'b1;
          in_ready[w_win_idx] = out_ready;
          if (out_ready) begin
            w_grant_nxt = w_win_idx;
            if (in_eop[w_win_idx]) w_rr_ptr_nxt = w_win_idx;
            else                   w_state_nxt  = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        w_fwd                 = 1'b1;
        out_valid             = in_valid[r_grant_idx];
        in_ready[r_grant_idx] = out_ready;
        if (in_valid[r_grant_idx] && out_ready && in_eop[r_grant_idx]) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = r_grant_idx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_fwd) begin
      out_sop   = in_sop[w_sel];
      out_eop   = in_eop[w_sel];
      out_data  = in_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
      out_empty = in_empty[int'(w_sel)*EMPTY_WIDTH +: EMPTY_WIDTH];
    end

    // Handshakes are blocked while reset is held, regardless of state.
    if (!rst) begin
      in_ready  = '0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= IDX_WIDTH'(NUM_PORTS - 1);
      r_grant_idx  <= '0;
      r_stray_drop <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_grant_idx  <= w_grant_nxt;
      r_stray_drop <= |w_drain;
    end
  end

  assign grant_idx  = r_grant_idx;
  assign busy       = (r_state == ST_LOCKED);
  assign stray_drop = r_stray_drop;

endmodule
`default_nettype wire

// File: tb/tb_avalon_packet_arbiter.sv
`default_nettype none
// Directed table-driven bench for avalon_packet_arbiter (4 ports, 8-bit data).
module tb_avalon_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0, in_ready, in_sop = '0, in_eop = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_empty = 4'b1010;
  logic        out_valid, out_ready = 1'b1, out_sop, out_eop;
  logic [7:0]  out_data;
  logic [0:0]  out_empty;
  logic [1:0]  grant_idx;
  logic        busy, stray_drop;

  int n_checks = 0;
  int n_errors = 0;

  avalon_packet_arbiter #(
    .DATA_WIDTH (8),
    .EMPTY_WIDTH(1),
    .NUM_PORTS  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_data  (out_data),
    .out_empty (out_empty),
    .grant_idx (grant_idx),
    .busy      (busy),
    .stray_drop(stray_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid, sop, eop;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov, e_osop, e_oeop;
    logic [7:0]  e_odata;
    logic        e_oempty;
    logic [1:0]  e_g;
    logic        e_busy, e_stray;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] s,
                              input logic [3:0] e, input logic [31:0] d, input logic o,
                              input logic [3:0] rdy, input logic ov, input logic os,
                              input logic oe, input logic [7:0] od, input logic oem,
                              input logic [1:0] g, input logic b, input logic st);
    vec_t x;
    x.rst_n = r; x.valid = v; x.sop = s; x.eop = e; x.data = d; x.ordy = o;
    x.e_rdy = rdy; x.e_ov = ov; x.e_osop = os; x.e_oeop = oe; x.e_odata = od;
    x.e_oempty = oem; x.e_g = g; x.e_busy = b; x.e_stray = st;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    rst       = v.rst_n;
    in_valid  = v.valid;
    in_sop    = v.sop;
    in_eop    = v.eop;
    in_data   = v.data;
    out_ready = v.ordy;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " in_ready"},   32'(in_ready),   32'(v.e_rdy));
    chk({tag, " out_valid"},  32'(out_valid),  32'(v.e_ov));
    chk({tag, " out_sop"},    32'(out_sop),    32'(v.e_osop));
    chk({tag, " out_eop"},    32'(out_eop),    32'(v.e_oeop));
    chk({tag, " out_data"},   32'(out_data),   32'(v.e_odata));
    chk({tag, " out_empty"},  32'(out_empty),  32'(v.e_oempty));
    chk({tag, " grant_idx"},  32'(grant_idx),  32'(v.e_g));
    chk({tag, " busy"},       32'(busy),       32'(v.e_busy));
    chk({tag, " stray_drop"}, 32'(stray_drop), 32'(v.e_stray));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[$];
    vec_t h;
    #1 rst = 1'b0;

    // Reset held: handshakes blocked even with beats presented.
    vecs.push_back(mk(0,4'hF,4'h0,4'h0,32'h30201000,1, 4'h0,0,0,0,8'h00,0,2'd0,0,0));
    // Four 3-beat packets, served 0,1,2,3 without interleaving.
    vecs.push_back(mk(1,4'hF,4'hF,4'h0,32'h30201000,1, 4'h1,1,1,0,8'h00,0,2'd0,0,0));
    vecs.push_back(mk(1,4'hF,4'hE,4'h0,32'h30201001,1, 4'h1,1,0,0,8'h01,0,2'd0,1,0));
    vecs.push_back(mk(1,4'hF,4'hE,4'h1,32'h30201002,1, 4'h1,1,0,1,8'h02,0,2'd0,1,0));
    vecs.push_back(mk(1,4'hE,4'hE,4'h0,32'h30201000,1, 4'h2,1,1,0,8'h10,1,2'd0,0,0));
    vecs.push_back(mk(1,4'hE,4'hC,4'h0,32'h30201100,1, 4'h2,1,0,0,8'h11,1,2'd1,1,0));
    vecs.push_back(mk(1,4'hE,4'hC,4'h2,32'h30201200,1, 4'h2,1,0,1,8'h12,1,2'd1,1,0));
    vecs.push_back(mk(1,4'hC,4'hC,4'h0,32'h30201200,1, 4'h4,1,1,0,8'h20,0,2'd1,0,0));
    vecs.push_back(mk(1,4'hC,4'h8,4'h0,32'h30211200,1, 4'h4,1,0,0,8'h21,0,2'd2,1,0));
    vecs.push_back(mk(1,4'hC,4'h8,4'h4,32'h30221200,1, 4'h4,1,0,1,8'h22,0,2'd2,1,0));
    vecs.push_back(mk(1,4'h8,4'h8,4'h0,32'h30221200,1, 4'h8,1,1,0,8'h30,1,2'd2,0,0));
    vecs.push_back(mk(1,4'h8,4'h0,4'h0,32'h31221200,1, 4'h8,1,0,0,8'h31,1,2'd3,1,0));
    vecs.push_back(mk(1,4'h8,4'h0,4'h8,32'h32221200,1, 4'h8,1,0,1,8'h32,1,2'd3,1,0));
    vecs.push_back(mk(1,4'h0,4'h0,4'h0,32'h00000000,1, 4'h0,0,0,0,8'h00,0,2'd3,0,0));
    // Single-beat packets: port 2 streaming, port 1 once -> 2,1,2,2.
    vecs.push_back(mk(1,4'h4,4'h4,4'h4,32'h00A00000,1, 4'h4,1,1,1,8'hA0,0,2'd3,0,0));
    vecs.push_back(mk(1,4'h6,4'h6,4'h6,32'h00A1B000,1, 4'h2,1,1,1,8'hB0,1,2'd2,0,0));
    vecs.push_back(mk(1,4'h4,4'h4,4'h4,32'h00A10000,1, 4'h4,1,1,1,8'hA1,0,2'd1,0,0));
    vecs.push_back(mk(1,4'h4,4'h4,4'h4,32'h00A20000,1, 4'h4,1,1,1,8'hA2,0,2'd2,0,0));
    // Stray beat 0xAA on port 1 is drained, never forwarded.
    vecs.push_back(mk(1,4'h2,4'h0,4'h0,32'h0000AA00,1, 4'h2,0,0,0,8'h00,0,2'd2,0,0));
    vecs.push_back(mk(1,4'h0,4'h0,4'h0,32'h00000000,1, 4'h0,0,0,0,8'h00,0,2'd2,0,1));
    vecs.push_back(mk(1,4'h0,4'h0,4'h0,32'h00000000,1, 4'h0,0,0,0,8'h00,0,2'd2,0,0));
    // Port 0 locked while port 3 waits; out_ready stalls the eop beat.
    vecs.push_back(mk(1,4'h1,4'h1,4'h0,32'h000000C0,1, 4'h1,1,1,0,8'hC0,0,2'd2,0,0));
    vecs.push_back(mk(1,4'h9,4'h8,4'h8,32'hD00000C1,1, 4'h1,1,0,0,8'hC1,0,2'd0,1,0));
    vecs.push_back(mk(1,4'h9,4'h8,4'h9,32'hD00000C2,0, 4'h0,1,0,1,8'hC2,0,2'd0,1,0));
    vecs.push_back(mk(1,4'h9,4'h8,4'h9,32'hD00000C2,1, 4'h1,1,0,1,8'hC2,0,2'd0,1,0));
    vecs.push_back(mk(1,4'h8,4'h8,4'h8,32'hD0000000,1, 4'h8,1,1,1,8'hD0,1,2'd0,0,0));
    // Stalled IDLE grant is re-arbitrated when a higher-priority sop arrives.
    vecs.push_back(mk(1,4'h4,4'h4,4'h4,32'h00E00000,0, 4'h0,1,1,1,8'hE0,0,2'd3,0,0));
    vecs.push_back(mk(1,4'h5,4'h5,4'h5,32'h00E000F0,1, 4'h1,1,1,1,8'hF0,0,2'd3,0,0));
    vecs.push_back(mk(1,4'h4,4'h4,4'h4,32'h00E00000,1, 4'h4,1,1,1,8'hE0,0,2'd0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted mid-packet (port 2, beat 2 of 4), between clock edges.
    @(negedge clk);
    h = mk(1,4'h4,4'h4,4'h0,32'h00500000,1, 4'h4,1,1,0,8'h50,0,2'd2,0,0);
    drive_vec(h); #1; check_vec("rst_b1", h);
    @(negedge clk);
    h = mk(1,4'h4,4'h0,4'h0,32'h00510000,1, 4'h4,1,0,0,8'h51,0,2'd2,1,0);
    drive_vec(h); #1; check_vec("rst_b2", h);
    #1 rst = 1'b0;
    #1;
    h = mk(0,4'h4,4'h0,4'h0,32'h00510000,1, 4'h0,0,0,0,8'h00,0,2'd0,0,0);
    check_vec("rst_held", h);
    @(negedge clk);
    h = mk(1,4'h4,4'h0,4'h0,32'h00510000,1, 4'h4,0,0,0,8'h00,0,2'd0,0,0);
    drive_vec(h); #1; check_vec("rst_drain1", h);
    @(negedge clk);
    h = mk(1,4'h4,4'h0,4'h0,32'h00520000,1, 4'h4,0,0,0,8'h00,0,2'd0,0,1);
    drive_vec(h); #1; check_vec("rst_drain2", h);
    @(negedge clk);
    h = mk(1,4'h4,4'h0,4'h4,32'h00530000,1, 4'h4,0,0,0,8'h00,0,2'd0,0,1);
    drive_vec(h); #1; check_vec("rst_drain3", h);
    @(negedge clk);
    h = mk(1,4'h1,4'h1,4'h1,32'h00000060,1, 4'h1,1,1,1,8'h60,0,2'd0,0,1);
    drive_vec(h); #1; check_vec("rst_p0_sop", h);
    @(negedge clk);
    h = mk(1,4'h0,4'h0,4'h0,32'h00000000,1, 4'h0,0,0,0,8'h00,0,2'd0,0,0);
    drive_vec(h); #1; check_vec("rst_idle", h);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
